// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and default widths for pipeline stage registers
//
// Contents:
//   ps_state_e    occupancy state of a stage: empty, main entry full, main+skid full
//   DEF_DATA_W    default channel width used by stage instantiations
//   DEF_NUM_CH    default channel count used by stage instantiations
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } ps_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NUM_CH = 2;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry
//
// Parameters:
//   DATA_W     width of one channel
//   NUM_CH     number of channels, channel 0 in the LSBs
//   SKID_EN    1: two entries, in_ready registered; 0: one entry, in_ready combinational
//   RESET_VAL  per-channel value loaded on reset and flush
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous squash of all held beats
//   in_valid   upstream beat present
//   in_ready   stage accepts a beat this cycle
//   in_data    upstream payload (NUM_CH*DATA_W)
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts (legacy stall maps to !stall)
//   out_data   oldest held beat (NUM_CH*DATA_W)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                NUM_CH    = DEF_NUM_CH,
    parameter int                SKID_EN   = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data
);

    localparam int W = NUM_CH * DATA_W;

    logic [W-1:0] rst_vec;
    ps_state_e    state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic         in_ready_c;
    logic         accept;
    logic         emit;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_rst_ch
        assign rst_vec[c*DATA_W +: DATA_W] = RESET_VAL;
    end

    assign out_valid = (state_q != PS_EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_c;
    assign accept    = in_valid && in_ready_c;
    assign emit      = out_valid && out_ready;

    // Main entry and state are shared by both modes; only next-state logic differs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PS_EMPTY;
            main_q  <= rst_vec;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    if (SKID_EN != 0) begin : g_skid
        logic [W-1:0] skid_q, skid_d;

        // Ready comes from state only, so out_ready never reaches in_ready.
        assign in_ready_c = !rst && (state_q != PS_SKID);

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        state_d = PS_FULL;
                        main_d  = in_data;
                    end
                end
                PS_FULL: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat behind main.
                        state_d = PS_SKID;
                        skid_d  = in_data;
                    end else if (emit) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_SKID: begin
                    if (emit) begin
                        state_d = PS_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
            if (flush) begin
                state_d = PS_EMPTY;
                main_d  = rst_vec;
                skid_d  = rst_vec;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                skid_q <= rst_vec;
            end else begin
                skid_q <= skid_d;
            end
        end
    end else begin : g_direct
        // A departing beat frees the single entry in the same cycle.
        assign in_ready_c = !rst && (!out_valid || out_ready);

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            if (accept) begin
                state_d = PS_FULL;
                main_d  = in_data;
            end else if (emit) begin
                state_d = PS_EMPTY;
            end
            if (flush) begin
                state_d = PS_EMPTY;
                main_d  = rst_vec;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg in both modes
module tb_pipe_stage_reg;

    localparam logic [31:0] N_RV = 32'hA5A5_0F0F;
    localparam logic [63:0] N_RV64 = {N_RV, N_RV};

    localparam logic [63:0] DA = 64'hA0A0_0001_0A0A_1001;
    localparam logic [63:0] DB = 64'hB0B0_0002_0B0B_2002;
    localparam logic [63:0] DC = 64'hC0C0_0003_0C0C_3003;
    localparam logic [63:0] DD = 64'hD0D0_0004_0D0D_4004;
    localparam logic [63:0] DE = 64'hE0E0_0005_0E0E_5005;
    localparam logic [63:0] DF = 64'hF0F0_0006_0F0F_6006;
    localparam logic [63:0] DG = 64'h1234_0007_4321_7007;
    localparam logic [63:0] DH = 64'h5678_0008_8765_8008;
    localparam logic [63:0] DI = 64'h9ABC_0009_CBA9_9009;
    localparam logic [63:0] DX = 64'hDEAD_BEEF_1234_5678;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst, s_flush, s_iv, s_ordy, s_ir, s_ov;
    logic [63:0] s_d, s_od;
    logic        n_rst, n_flush, n_iv, n_ordy, n_ir, n_ov;
    logic [63:0] n_d, n_od;

    pipe_stage_reg #(.DATA_W(32), .NUM_CH(2), .SKID_EN(1), .RESET_VAL(32'h0)) dut_s (
        .clk(clk), .rst(s_rst), .flush(s_flush),
        .in_valid(s_iv), .in_ready(s_ir), .in_data(s_d),
        .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_od)
    );

    pipe_stage_reg #(.DATA_W(32), .NUM_CH(2), .SKID_EN(0), .RESET_VAL(N_RV)) dut_n (
        .clk(clk), .rst(n_rst), .flush(n_flush),
        .in_valid(n_iv), .in_ready(n_ir), .in_data(n_d),
        .out_valid(n_ov), .out_ready(n_ordy), .out_data(n_od)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_od;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [63:0] d,
                                input logic o, input logic eir, input logic eov, input logic [63:0] eod);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = o;
        v.e_ir = eir; v.e_ov = eov; v.e_od = eod;
        return v;
    endfunction

    vec_t tv[36];

    logic [63:0] q_s[$];
    logic [63:0] q_n[$];

    initial begin
        // Skid-mode cycle table: outputs are what is visible before that cycle's edge.
        tv[0]  = mk(1, 0, 1, DX, 0, 0, 0, 64'd0);
        tv[1]  = mk(1, 0, 1, DX, 0, 0, 0, 64'd0);
        tv[2]  = mk(0, 0, 0, 64'd0, 1, 1, 0, 64'd0);
        tv[3]  = mk(0, 0, 0, 64'd0, 1, 1, 0, 64'd0);
        for (int k = 1; k <= 8; k++)
            tv[3+k] = mk(0, 0, 1, 64'(k), 1, 1, (k > 1), (k > 1) ? 64'(k-1) : 64'd0);
        tv[12] = mk(0, 0, 0, 64'd0, 1, 1, 1, 64'd8);
        tv[13] = mk(0, 0, 0, 64'd0, 1, 1, 0, 64'd8);
        tv[14] = mk(0, 0, 1, DA, 0, 1, 0, 64'd8);
        tv[15] = mk(0, 0, 1, DB, 0, 1, 1, DA);
        tv[16] = mk(0, 0, 1, DC, 0, 0, 1, DA);
        tv[17] = mk(0, 0, 1, DC, 0, 0, 1, DA);
        tv[18] = mk(0, 0, 1, DC, 1, 0, 1, DA);
        tv[19] = mk(0, 0, 1, DC, 1, 1, 1, DB);
        tv[20] = mk(0, 0, 0, 64'd0, 1, 1, 1, DC);
        tv[21] = mk(0, 0, 0, 64'd0, 1, 1, 0, DC);
        tv[22] = mk(0, 0, 1, DA, 0, 1, 0, DC);
        tv[23] = mk(0, 0, 1, DB, 0, 1, 1, DA);
        tv[24] = mk(0, 1, 1, DD, 0, 0, 1, DA);
        tv[25] = mk(0, 0, 0, 64'd0, 1, 1, 0, 64'd0);
        tv[26] = mk(0, 0, 0, 64'd0, 1, 1, 0, 64'd0);
        tv[27] = mk(0, 0, 1, DE, 0, 1, 0, 64'd0);
        tv[28] = mk(0, 1, 1, DF, 1, 1, 1, DE);
        tv[29] = mk(0, 0, 0, 64'd0, 1, 1, 0, 64'd0);
        tv[30] = mk(0, 0, 1, DG, 0, 1, 0, 64'd0);
        tv[31] = mk(1, 0, 1, DH, 0, 0, 1, DG);
        tv[32] = mk(0, 0, 0, 64'd0, 0, 1, 0, 64'd0);
        tv[33] = mk(0, 0, 1, DI, 0, 1, 0, 64'd0);
        tv[34] = mk(1, 1, 0, 64'd0, 0, 0, 1, DI);
        tv[35] = mk(0, 0, 0, 64'd0, 0, 1, 0, 64'd0);

        s_rst = 1; s_flush = 0; s_iv = 0; s_d = '0; s_ordy = 0;
        n_rst = 1; n_flush = 0; n_iv = 0; n_d = '0; n_ordy = 0;
        step();

        for (int i = 0; i < 36; i++) begin
            s_rst = tv[i].rst; s_flush = tv[i].flush; s_iv = tv[i].iv;
            s_d = tv[i].d; s_ordy = tv[i].ordy;
            #1;
            chk($sformatf("skid_vec%0d_in_ready", i), 64'(s_ir), 64'(tv[i].e_ir));
            chk($sformatf("skid_vec%0d_out_valid", i), 64'(s_ov), 64'(tv[i].e_ov));
            chk($sformatf("skid_vec%0d_out_data", i), s_od, tv[i].e_od);
            step();
        end

        // in_ready must not follow out_ready within a cycle in skid mode.
        s_rst = 0; s_flush = 0; s_iv = 1; s_d = DA; s_ordy = 0;
        step();
        #1; chk("skid_full_ir_ordy0", 64'(s_ir), 64'd1);
        s_ordy = 1; #1; chk("skid_full_ir_ordy1", 64'(s_ir), 64'd1);
        s_ordy = 0; s_d = DB; #1;
        step();
        #1; chk("skid_skid_ir_ordy0", 64'(s_ir), 64'd0);
        s_ordy = 1; #1; chk("skid_skid_ir_ordy1", 64'(s_ir), 64'd0);
        s_iv = 0;
        step();
        chk("skid_drain_b", s_od, DB);
        step();
        chk("skid_drain_empty", 64'(s_ov), 64'd0);

        // Single-entry mode: reset, streaming, combinational ready, flush.
        #1;
        chk("dir_rst_ir", 64'(n_ir), 64'd0);
        chk("dir_rst_ov", 64'(n_ov), 64'd0);
        chk("dir_rst_od", n_od, N_RV64);
        n_rst = 0; n_ordy = 1;
        step();
        chk("dir_post_rst_ir", 64'(n_ir), 64'd1);
        chk("dir_post_rst_ov", 64'(n_ov), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            n_iv = 1; n_d = 64'(k);
            #1;
            chk($sformatf("dir_stream%0d_ir", k), 64'(n_ir), 64'd1);
            chk($sformatf("dir_stream%0d_ov", k), 64'(n_ov), 64'(k > 1));
            if (k > 1) chk($sformatf("dir_stream%0d_od", k), n_od, 64'(k-1));
            step();
        end
        n_iv = 0;
        #1; chk("dir_stream_last_od", n_od, 64'd8);
        step();
        chk("dir_stream_empty", 64'(n_ov), 64'd0);

        n_iv = 1; n_d = DA; n_ordy = 0;
        step();
        n_d = DB;
        #1; chk("dir_full_stall_ir", 64'(n_ir), 64'd0);
        chk("dir_full_od_a", n_od, DA);
        n_ordy = 1;
        #1; chk("dir_comb_ir", 64'(n_ir), 64'd1);
        step();
        chk("dir_replace_ov", 64'(n_ov), 64'd1);
        chk("dir_replace_od", n_od, DB);
        n_iv = 1; n_d = DC; n_flush = 1;
        step();
        n_flush = 0; n_iv = 0;
        #1; chk("dir_flush_ov", 64'(n_ov), 64'd0);
        chk("dir_flush_od", n_od, N_RV64);

        // Random traffic against scoreboard queues, both modes side by side.
        s_rst = 1; n_rst = 1;
        step();
        s_rst = 0; n_rst = 0;
        begin
            logic        sp_hold, np_hold;
            logic [63:0] sp_od, np_od;
            logic        acc, emi;
            sp_hold = 0; np_hold = 0; sp_od = '0; np_od = '0;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                s_iv = ($urandom_range(0, 3) != 0);
                s_ordy = ($urandom_range(0, 2) != 0);
                s_flush = ($urandom_range(0, 31) == 0);
                s_d = {$urandom, $urandom};
                n_iv = ($urandom_range(0, 3) != 0);
                n_ordy = ($urandom_range(0, 2) != 0);
                n_flush = ($urandom_range(0, 31) == 0);
                n_d = {$urandom, $urandom};
                #2;
                chk("rnd_skid_ir", 64'(s_ir), 64'(q_s.size() < 2));
                chk("rnd_skid_ov", 64'(s_ov), 64'(q_s.size() != 0));
                if (q_s.size() != 0) chk("rnd_skid_od", s_od, q_s[0]);
                if (sp_hold) chk("rnd_skid_stable", s_od, sp_od);
                chk("rnd_dir_ir", 64'(n_ir), 64'(q_n.size() == 0 || n_ordy));
                chk("rnd_dir_ov", 64'(n_ov), 64'(q_n.size() != 0));
                if (q_n.size() != 0) chk("rnd_dir_od", n_od, q_n[0]);
                if (np_hold) chk("rnd_dir_stable", n_od, np_od);

                sp_hold = s_ov && !s_ordy && !s_flush;
                sp_od = s_od;
                acc = s_iv && (q_s.size() < 2);
                emi = (q_s.size() != 0) && s_ordy;
                if (s_flush) q_s.delete();
                else begin
                    if (emi) void'(q_s.pop_front());
                    if (acc) q_s.push_back(s_d);
                end

                np_hold = n_ov && !n_ordy && !n_flush;
                np_od = n_od;
                emi = (q_n.size() != 0) && n_ordy;
                acc = n_iv && (q_n.size() == 0 || n_ordy);
                if (n_flush) q_n.delete();
                else begin
                    if (emi) void'(q_n.pop_front());
                    if (acc) q_n.push_back(n_d);
                end
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
